fp_add_sched: RTL and testbench
===============================

FP_ADD_SCHED -- requirements
Module: fp_add_sched

Interface
REQ-001 Parameter: W, default 32, operand/result width.
REQ-002 Parameter: RMW, default 3, rounding-mode field width.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid, req1_valid  input  1 each  requester N has an add operation pending.
REQ-006 req0_ready, req1_ready  output  1 each  requester N's operation is accepted this cycle (valid&ready at the rising edge).
REQ-007 req0_a, req0_b, req1_a, req1_b  input  W each  operands for requester N.
REQ-008 req0_rm, req1_rm  input  RMW each  rounding mode for requester N.
REQ-009 add_in1, add_in2  output  W each  registered operands driven to the shared fp_add.
REQ-010 add_round_m  output  RMW  registered rounding mode driven to the shared fp_add.
REQ-011 add_out  input  W  fp_add result.
REQ-012 add_ov, add_un, add_inv, add_inexact  input  1 each  fp_add flags.
REQ-013 rsp0_valid, rsp1_valid  output  1 each  a result for requester N is on rsp_data/rsp_flags this cycle; single-cycle pulse with no backpressure.
REQ-014 rsp_data  output  W  result, equal to add_out.
REQ-015 rsp_flags  output  4  {ov,un,inv,inexact}, equal to the fp_add flags.
REQ-016 busy  output  1  at least one operation is in flight.

Function
REQ-017 Shared-unit timing: fp_add samples add_in1/add_in2/add_round_m at stage 1, then at stage 2 the rounding consumes add_round_m. The result is registered two edges after operands are presented.
REQ-018 Acceptance in cycle c: at the edge ending c, the scheduler SHALL load add_in1=a, add_in2=b and add_round_m=rm.
REQ-019 The result of an operation accepted in cycle c SHALL appear as rsp_valid in cycle c+3. Latency is fixed at 3 cycles.
REQ-020 Throughput: 1 operation per cycle while consecutive accepted operations carry equal rm.
REQ-021 rm hazard: add_round_m serves stage 1 of the newer operation and stage 2 of the older one in the same cycle. Acceptance in cycle c+1 is therefore blocked when an operation was accepted in cycle c with a different rm.
REQ-022 A blocked cycle is a bubble. During a bubble, add_round_m, add_in1 and add_in2 hold their values.
REQ-023 Arbitration: round-robin with a 1-bit priority pointer.
REQ-024 When both requesters are valid and eligible, the requester selected by the pointer is granted.
REQ-025 After any grant, the pointer moves to the non-granted requester.
REQ-026 When only one requester is valid and eligible, it is granted regardless of the pointer.
REQ-027 At most one of req0_ready/req1_ready is high per cycle.
REQ-028 ready is a combinational function of req*_valid, req*_rm, pointer and hazard state, and is 0 when the corresponding valid is 0.
REQ-029 A requester blocked by the rm hazard does not prevent granting the other requester if the other is hazard-free.
REQ-030 Tag pipeline: 3-stage shift register of {valid, requester id}. Stage 0 is loaded on acceptance and stage 2 drives rsp0_valid/rsp1_valid.
REQ-031 FSM states:
- IDLE: nothing accepted in the previous cycle.
- RUN: accepted last cycle; last_rm is valid.
- STALL: a hazard bubble this cycle.
REQ-032 FSM transitions:
- IDLE -> RUN on acceptance.
- RUN -> RUN on same-rm acceptance.
- RUN -> STALL when a valid request is blocked by the hazard and nothing is accepted.
- RUN -> IDLE when no valid request is pending.
- STALL -> RUN on acceptance (any rm, since the hazard has cleared).
- STALL -> IDLE otherwise.
REQ-033 In-flight counter, 0..3: +1 on acceptance, -1 on rsp_valid, unchanged when both occur in the same cycle. busy = (counter != 0).
REQ-034 rsp_data and rsp_flags are passed through combinationally. Their values are don't-care when no rsp_valid is high.

Reset
REQ-035 While rst is high, the following SHALL be 0: req*_ready, rsp*_valid, busy, add_in1, add_in2, add_round_m, all tag stages, the counter and the pointer. The pointer value 0 favours requester 0.
REQ-036 FSM resets to IDLE.
REQ-037 Reset asserted mid-operation discards all in-flight tags. No rsp_valid is produced for operations accepted before reset.
REQ-038 The first acceptance is possible in the first cycle after rst deasserts.

Verification
REQ-039 Single op: req0 a=0x3F800000, b=0x40000000, rm=0, accepted in cycle 0. Required: add_in1/add_in2 equal the operands in cycle 1; rsp0_valid=1 only in cycle 3, with rsp_data=0x40400000.
REQ-040 Contention: both valid every cycle with rm=0 for 6 cycles after reset. Required: grants alternate 0,1,0,1,0,1; rsp valids alternate starting in cycle 3; busy stays 1 until the last response.
REQ-041 Hazard: req0 rm=0 accepted in cycle c, then req1 rm=1 valid in cycle c+1. Required: req1_ready=0 in c+1 (STALL), req1 accepted in c+2, add_round_m=0 through c+1, and responses in c+3 and c+5.
REQ-042 Hazard bypass: req0 rm=1 blocked after an rm=0 op while req1 rm=0 is valid. Required: req1 is granted in the same cycle.
REQ-043 Reset mid-flight: assert rst one cycle after two acceptances. Required: all outputs read 0 immediately, no rsp_valid follows, and busy=0.

Source files
------------

// File: rtl/fp_add_sched_if.sv
// Bundle between fp_add_sched, its two requesters and the shared fp_add.
// The slave modport is the scheduler's view; master is the environment's view.
interface fp_add_sched_if #(
  parameter int W   = 32,
  parameter int RMW = 3
);
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic [RMW-1:0] req0_rm, req1_rm;
  logic [W-1:0]   add_in1, add_in2;
  logic [RMW-1:0] add_round_m;
  logic [W-1:0]   add_out;
  logic           add_ov, add_un, add_inv, add_inexact;
  logic           rsp0_valid, rsp1_valid;
  logic [W-1:0]   rsp_data;
  logic [3:0]     rsp_flags;
  logic           busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_rm, req1_rm, add_out, add_ov, add_un, add_inv, add_inexact,
    output req0_ready, req1_ready, add_in1, add_in2, add_round_m,
           rsp0_valid, rsp1_valid, rsp_data, rsp_flags, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_rm, req1_rm, add_out, add_ov, add_un, add_inv, add_inexact,
    input  req0_ready, req1_ready, add_in1, add_in2, add_round_m,
           rsp0_valid, rsp1_valid, rsp_data, rsp_flags, busy
  );
endinterface

// File: rtl/fp_add_sched.sv
// Two-requester scheduler for a shared two-stage fp_add: round-robin grant,
// rounding-mode hazard interlock, fixed 3-cycle response tagging.
module fp_add_sched #(
  parameter int W   = 32,
  parameter int RMW = 3
) (
  input logic           clk,
  input logic           rst,
  fp_add_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   in1_reg, in2_reg;
  logic [RMW-1:0] rm_reg;
  logic           ptr_reg;
  logic [2:0]     tag_v_reg, tag_id_reg;
  logic [1:0]     cnt_reg, cnt_next;
  logic           hazard, elig0, elig1, grant0, grant1, accept, rsp_any;
  logic [W-1:0]   sel_a, sel_b;
  logic [RMW-1:0] sel_rm;

  // In RUN, rm_reg is the rm of the op now in fp_add stage 1; it must not change yet.
  assign hazard = (state_reg == RUN);
  assign elig0  = bus.req0_valid && !(hazard && (bus.req0_rm != rm_reg));
  assign elig1  = bus.req1_valid && !(hazard && (bus.req1_rm != rm_reg));
  assign grant0 = !rst && elig0 && (!elig1 || !ptr_reg);
  assign grant1 = !rst && elig1 && (!elig0 || ptr_reg);
  assign accept = grant0 || grant1;

  assign sel_a  = grant1 ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant1 ? bus.req1_b  : bus.req0_b;
  assign sel_rm = grant1 ? bus.req1_rm : bus.req0_rm;

  assign rsp_any = tag_v_reg[2];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE:    state_next = accept ? RUN : IDLE;
      RUN: begin
        if (accept)
          state_next = RUN;
        else if (bus.req0_valid || bus.req1_valid)
          state_next = STALL;
        else
          state_next = IDLE;
      end
      STALL:   state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
    if (accept && !rsp_any)
      cnt_next = cnt_reg + 2'd1;
    else if (!accept && rsp_any)
      cnt_next = cnt_reg - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      in1_reg    <= '0;
      in2_reg    <= '0;
      rm_reg     <= '0;
      ptr_reg    <= 1'b0;
      tag_v_reg  <= '0;
      tag_id_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Operand registers hold through bubbles so fp_add stage 2 keeps its rm.
      if (accept) begin
        in1_reg <= sel_a;
        in2_reg <= sel_b;
        rm_reg  <= sel_rm;
        ptr_reg <= ~grant1;
      end
      tag_v_reg  <= {tag_v_reg[1:0], accept};
      tag_id_reg <= {tag_id_reg[1:0], grant1};
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.add_in1     = in1_reg;
  assign bus.add_in2     = in2_reg;
  assign bus.add_round_m = rm_reg;
  assign bus.rsp0_valid  = tag_v_reg[2] && !tag_id_reg[2];
  assign bus.rsp1_valid  = tag_v_reg[2] && tag_id_reg[2];
  assign bus.rsp_data    = bus.add_out;
  assign bus.rsp_flags   = {bus.add_ov, bus.add_un, bus.add_inv, bus.add_inexact};
  assign bus.busy        = (cnt_reg != 2'd0);
endmodule

// File: tb/tb_fp_add_sched.sv
// Bench for fp_add_sched: a two-stage fp_add stand-in, a queue-based reference
// of grants/responses, a contention vector table, hand sequences and random traffic.
module tb_fp_add_sched;
  logic clk = 1'b0;
  logic rst;

  fp_add_sched_if #(.W(32), .RMW(3)) bus ();
  fp_add_sched #(.W(32), .RMW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic real f2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] fp32_add(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] d;
    logic [10:0] e;
    logic [10:0] e32;
    d = $realtobits(f2r(x) + f2r(y));
    e = d[62:52];
    if (e <= 11'd896) return {d[63], 31'd0};
    e32 = e - 11'd896;
    return {d[63], e32[7:0], d[51:29]};
  endfunction

  // Stand-in unit: the rounding mode only matters at stage 2, marked into the result LSBs.
  function automatic logic [31:0] unit_data(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    return fp32_add(x, y) ^ {29'd0, rm};
  endfunction

  function automatic logic [3:0] unit_flags(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    return x[3:0] ^ y[7:4] ^ {1'b0, rm};
  endfunction

  logic [31:0] s1a, s1b, res;
  logic [3:0]  resf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1a <= '0; s1b <= '0; res <= '0; resf <= '0;
    end else begin
      s1a  <= bus.add_in1;
      s1b  <= bus.add_in2;
      res  <= unit_data(s1a, s1b, bus.add_round_m);
      resf <= unit_flags(s1a, s1b, bus.add_round_m);
    end
  end
  assign bus.add_out = res;
  assign {bus.add_ov, bus.add_un, bus.add_inv, bus.add_inexact} = resf;

  // Reference model state
  typedef struct packed {
    int          due;
    bit          id;
    logic [31:0] data;
    logic [3:0]  flags;
  } exp_t;
  exp_t        q[$];
  int          cyc = 0;
  int          last_acc = -100;
  logic [2:0]  last_rm = '0;
  bit          ptr_m = 1'b0;
  logic [31:0] exp_in1 = '0, exp_in2 = '0;
  logic [2:0]  exp_rm = '0;

  bit          in_v0, in_v1;
  logic [2:0]  in_rm0, in_rm1;
  logic [31:0] in_a0, in_b0, in_a1, in_b1;

  logic        obs_r0, obs_r1, obs_s0, obs_s1, obs_busy;
  logic [2:0]  obs_rm;
  logic [31:0] obs_data, obs_in1, obs_in2;
  logic [3:0]  obs_flags;

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'(120 + $urandom_range(0, 15));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic drive();
    bus.req0_valid = in_v0; bus.req1_valid = in_v1;
    bus.req0_rm = in_rm0;   bus.req1_rm = in_rm1;
    bus.req0_a = in_a0; bus.req0_b = in_b0;
    bus.req1_a = in_a1; bus.req1_b = in_b1;
  endtask

  task automatic model_reset();
    q.delete();
    last_acc = -100;
    last_rm  = '0;
    ptr_m    = 1'b0;
    exp_in1 = '0; exp_in2 = '0; exp_rm = '0;
  endtask

  task automatic model_step();
    bit hz, e0, e1, g0, g1, x0, x1;
    exp_t ent;
    hz = (last_acc == cyc - 1);
    e0 = in_v0 && !(hz && (in_rm0 != last_rm));
    e1 = in_v1 && !(hz && (in_rm1 != last_rm));
    g0 = e0 && (!e1 || !ptr_m);
    g1 = e1 && (!e0 || ptr_m);
    chk("ready0", obs_r0, g0);
    chk("ready1", obs_r1, g1);
    x0 = 1'b0; x1 = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      x0 = !q[0].id;
      x1 = q[0].id;
    end
    chk("rsp0_valid", obs_s0, x0);
    chk("rsp1_valid", obs_s1, x1);
    if (x0 || x1) begin
      chk("rsp_data", obs_data, q[0].data);
      chk("rsp_flags", obs_flags, q[0].flags);
    end
    chk("busy", obs_busy, q.size() != 0);
    chk("add_in1", obs_in1, exp_in1);
    chk("add_in2", obs_in2, exp_in2);
    chk("add_round_m", obs_rm, exp_rm);
    if (x0 || x1) void'(q.pop_front());
    if (g0 || g1) begin
      ent.due = cyc + 3;
      ent.id  = g1;
      exp_in1 = g1 ? in_a1 : in_a0;
      exp_in2 = g1 ? in_b1 : in_b0;
      exp_rm  = g1 ? in_rm1 : in_rm0;
      ent.data  = unit_data(exp_in1, exp_in2, exp_rm);
      ent.flags = unit_flags(exp_in1, exp_in2, exp_rm);
      q.push_back(ent);
      last_acc = cyc;
      last_rm  = exp_rm;
      ptr_m    = !g1;
    end
  endtask

  task automatic run_cycle(input bit v0, input bit v1, input logic [2:0] rm0, input logic [2:0] rm1,
                           input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1);
    in_v0 = v0; in_v1 = v1; in_rm0 = rm0; in_rm1 = rm1;
    in_a0 = a0; in_b0 = b0; in_a1 = a1; in_b1 = b1;
    drive();
    @(negedge clk);
    obs_r0 = bus.req0_ready; obs_r1 = bus.req1_ready;
    obs_s0 = bus.rsp0_valid; obs_s1 = bus.rsp1_valid;
    obs_busy = bus.busy; obs_rm = bus.add_round_m;
    obs_data = bus.rsp_data; obs_flags = bus.rsp_flags;
    obs_in1 = bus.add_in1; obs_in2 = bus.add_in2;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, rand_fp(), rand_fp(), rand_fp(), rand_fp());
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready0"}, bus.req0_ready, 1'b0);
    chk({tag, "_ready1"}, bus.req1_ready, 1'b0);
    chk({tag, "_rsp0"}, bus.rsp0_valid, 1'b0);
    chk({tag, "_rsp1"}, bus.rsp1_valid, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_in1"}, bus.add_in1, 32'd0);
    chk({tag, "_in2"}, bus.add_in2, 32'd0);
    chk({tag, "_rm"}, bus.add_round_m, 3'd0);
  endtask

  typedef struct packed {
    bit v0, v1;
    logic [2:0] rm0, rm1;
    bit r0, r1, s0, s1, busy;
  } vec_t;
  vec_t tbl[10];

  initial begin
    // Both requesters hammering with rm=0 right after reset
    tbl[0] = '{1, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 1, 0, 0, 1};
    tbl[2] = '{1, 1, 0, 0, 1, 0, 0, 0, 1};
    tbl[3] = '{1, 1, 0, 0, 0, 1, 1, 0, 1};
    tbl[4] = '{1, 1, 0, 0, 1, 0, 0, 1, 1};
    tbl[5] = '{1, 1, 0, 0, 0, 1, 1, 0, 1};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    in_v0 = 1; in_v1 = 1; in_rm0 = 0; in_rm1 = 0;
    in_a0 = '0; in_b0 = '0; in_a1 = '0; in_b1 = '0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_cycle(tbl[i].v0, tbl[i].v1, tbl[i].rm0, tbl[i].rm1, rand_fp(), rand_fp(), rand_fp(), rand_fp());
      chk($sformatf("tbl%0d_ready0", i), obs_r0, tbl[i].r0);
      chk($sformatf("tbl%0d_ready1", i), obs_r1, tbl[i].r1);
      chk($sformatf("tbl%0d_rsp0", i), obs_s0, tbl[i].s0);
      chk($sformatf("tbl%0d_rsp1", i), obs_s1, tbl[i].s1);
      chk($sformatf("tbl%0d_busy", i), obs_busy, tbl[i].busy);
    end

    // Single op, 1.0 + 2.0
    idle(2);
    run_cycle(1, 0, 0, 0, 32'h3F800000, 32'h40000000, '0, '0);
    chk("sop_accept", obs_r0, 1'b1);
    run_cycle(0, 0, 0, 0, '0, '0, '0, '0);
    chk("sop_in1", obs_in1, 32'h3F800000);
    chk("sop_in2", obs_in2, 32'h40000000);
    run_cycle(0, 0, 0, 0, '0, '0, '0, '0);
    chk("sop_rsp_early", obs_s0, 1'b0);
    run_cycle(0, 0, 0, 0, '0, '0, '0, '0);
    chk("sop_rsp", obs_s0, 1'b1);
    chk("sop_data", obs_data, 32'h40400000);
    run_cycle(0, 0, 0, 0, '0, '0, '0, '0);
    chk("sop_rsp_late", obs_s0, 1'b0);

    // rm hazard stalls the follower by one bubble
    idle(3);
    run_cycle(1, 0, 0, 0, rand_fp(), rand_fp(), '0, '0);
    chk("hz_acc0", obs_r0, 1'b1);
    run_cycle(0, 1, 0, 1, '0, '0, rand_fp(), rand_fp());
    chk("hz_blocked", obs_r1, 1'b0);
    chk("hz_rm_c1", obs_rm, 3'd0);
    run_cycle(0, 1, 0, 1, '0, '0, rand_fp(), rand_fp());
    chk("hz_acc1", obs_r1, 1'b1);
    chk("hz_rm_c2", obs_rm, 3'd0);
    run_cycle(0, 0, 0, 0, '0, '0, '0, '0);
    chk("hz_rsp0", obs_s0, 1'b1);
    run_cycle(0, 0, 0, 0, '0, '0, '0, '0);
    chk("hz_gap", {obs_s0, obs_s1}, 2'b00);
    run_cycle(0, 0, 0, 0, '0, '0, '0, '0);
    chk("hz_rsp1", obs_s1, 1'b1);

    // Blocked requester does not stall a hazard-free one
    idle(3);
    run_cycle(0, 1, 0, 0, '0, '0, rand_fp(), rand_fp());
    chk("byp_acc1", obs_r1, 1'b1);
    run_cycle(1, 1, 1, 0, rand_fp(), rand_fp(), rand_fp(), rand_fp());
    chk("byp_grant1", obs_r1, 1'b1);
    chk("byp_block0", obs_r0, 1'b0);
    run_cycle(1, 0, 1, 0, rand_fp(), rand_fp(), '0, '0);
    chk("byp_still_block0", obs_r0, 1'b0);
    run_cycle(1, 0, 1, 0, rand_fp(), rand_fp(), '0, '0);
    chk("byp_acc0", obs_r0, 1'b1);

    // Reset one cycle after two acceptances
    idle(4);
    run_cycle(1, 0, 0, 0, rand_fp(), rand_fp(), '0, '0);
    run_cycle(0, 1, 0, 0, '0, '0, rand_fp(), rand_fp());
    in_v0 = 1; in_v1 = 1;
    drive();
    rst = 1'b1;
    #1;
    reset_checks("mid");
    @(negedge clk);
    reset_checks("mid_hold");
    in_v0 = 0; in_v1 = 0;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc += 2;
    for (int i = 0; i < 4; i++) begin
      run_cycle(0, 0, 0, 0, '0, '0, '0, '0);
      chk($sformatf("post_rst%0d_rsp", i), {obs_s0, obs_s1}, 2'b00);
      chk($sformatf("post_rst%0d_busy", i), obs_busy, 1'b0);
    end

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r0, r1;
      r0 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      r1 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, r0, r1,
                rand_fp(), rand_fp(), rand_fp(), rand_fp());
    end
    idle(5);
    chk("drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
